// File: rtl/health_pkg.sv
// Shared types and constants for the fighter health stage.
// Optional post-hit invulnerability is enabled with HEALTH_INVULN_EN.
package health_pkg;

    localparam int unsigned HEALTH_W           = 8;
    localparam int unsigned MAX_HEALTH_DEFAULT = 246;

    typedef logic [HEALTH_W-1:0] health_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFight  = 2'd1,
        StKoHold = 2'd2,
        StDone   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        WinNone  = 2'b00,
        WinRyu   = 2'b01,
        WinAkuma = 2'b10,
        WinDraw  = 2'b11
    } winner_e;

    // Subtract damage, clamping at zero instead of wrapping.
    function automatic health_t sat_sub(input health_t a, input health_t b);
        return (b >= a) ? '0 : health_t'(a - b);
    endfunction

endpackage

// File: rtl/health_channel.sv
// One fighter's true health, frame-drained displayed health and, with
// HEALTH_INVULN_EN defined, a post-hit invulnerability frame counter.
module health_channel
    import health_pkg::*;
#(
    parameter int unsigned MAX_HEALTH    = MAX_HEALTH_DEFAULT,
    parameter int unsigned DRAIN_STEP    = 2
`ifdef HEALTH_INVULN_EN
    ,
    parameter int unsigned INVULN_FRAMES = 30
`endif
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                hit_i,
    input  logic [HEALTH_W-1:0] damage_i,
    input  logic                frame_tick_i,
    input  logic                enable_i,
    input  logic                reload_i,
    output logic [HEALTH_W-1:0] true_o,
    output logic [HEALTH_W-1:0] disp_o
);

    localparam health_t MaxH = health_t'(MAX_HEALTH);
    localparam health_t Step = health_t'(DRAIN_STEP);

    health_t true_q, true_d;
    health_t disp_q, disp_d;
    logic    hit_accept;

`ifdef HEALTH_INVULN_EN
    localparam int unsigned InvW = (INVULN_FRAMES == 0) ? 1 : $clog2(INVULN_FRAMES + 1);

    logic [InvW-1:0] inv_q, inv_d;

    assign hit_accept = enable_i && hit_i && (inv_q == '0);

    always_comb begin
        inv_d = inv_q;
        if (reload_i) begin
            inv_d = '0;
        end else if (hit_accept) begin
            inv_d = InvW'(INVULN_FRAMES);
        end else if (frame_tick_i && (inv_q != '0)) begin
            inv_d = inv_q - InvW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inv_q <= '0;
        end else begin
            inv_q <= inv_d;
        end
    end
`else
    assign hit_accept = enable_i && hit_i;
`endif

    // Drain compares against the registered (pre-hit) true value.
    always_comb begin
        true_d = true_q;
        disp_d = disp_q;
        if (reload_i) begin
            true_d = MaxH;
            disp_d = MaxH;
        end else begin
            if (hit_accept) begin
                true_d = sat_sub(true_q, damage_i);
            end
            if (frame_tick_i && (disp_q > true_q)) begin
                disp_d = (health_t'(disp_q - true_q) > Step) ? health_t'(disp_q - Step) : true_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            true_q <= MaxH;
            disp_q <= MaxH;
        end else begin
            true_q <= true_d;
            disp_q <= disp_d;
        end
    end

    assign true_o = true_q;
    assign disp_o = disp_q;

endmodule

// File: rtl/health_manager.sv
// Round FSM, KO hold counter and winner latch around two health channels.
// Define HEALTH_INVULN_EN to enable per-fighter post-hit invulnerability.
module health_manager
    import health_pkg::*;
#(
    parameter int unsigned MAX_HEALTH     = MAX_HEALTH_DEFAULT,
    parameter int unsigned DRAIN_STEP     = 2,
    parameter int unsigned KO_HOLD_FRAMES = 120
`ifdef HEALTH_INVULN_EN
    ,
    parameter int unsigned INVULN_FRAMES  = 30
`endif
) (
    input  logic                vga_clk,
    input  logic                Reset_n,
    input  logic                frame_tick,
    input  logic                round_start,
    input  logic                RyuHit,
    input  logic [HEALTH_W-1:0] RyuDamage,
    input  logic                AkumaHit,
    input  logic [HEALTH_W-1:0] AkumaDamage,
    output logic [HEALTH_W-1:0] RyuHealth,
    output logic [HEALTH_W-1:0] AkumaHealth,
    output logic                RyuKO,
    output logic                AkumaKO,
    output logic [1:0]          winner,
    output logic                round_over
);

    localparam int unsigned HoldW = (KO_HOLD_FRAMES == 0) ? 1 : $clog2(KO_HOLD_FRAMES + 1);

    state_e          state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    winner_e         winner_q, winner_d;
    logic            ryu_ko_q, ryu_ko_d;
    logic            akuma_ko_q, akuma_ko_d;
    logic            round_over_q, round_over_d;

    health_t ryu_true, ryu_disp, akuma_true, akuma_disp;
    logic    hits_en, drain_tick, settled, ryu_zero, akuma_zero;

    assign hits_en    = (state_q == StFight);
    assign drain_tick = frame_tick && ((state_q == StFight) || (state_q == StKoHold));
    assign settled    = (ryu_disp == ryu_true) && (akuma_disp == akuma_true);
    assign ryu_zero   = (ryu_true == '0);
    assign akuma_zero = (akuma_true == '0);

    health_channel #(
        .MAX_HEALTH    (MAX_HEALTH),
        .DRAIN_STEP    (DRAIN_STEP)
`ifdef HEALTH_INVULN_EN
        ,
        .INVULN_FRAMES (INVULN_FRAMES)
`endif
    ) u_ryu (
        .clk_i        (vga_clk),
        .rst_ni       (Reset_n),
        .hit_i        (RyuHit),
        .damage_i     (RyuDamage),
        .frame_tick_i (drain_tick),
        .enable_i     (hits_en),
        .reload_i     (round_start),
        .true_o       (ryu_true),
        .disp_o       (ryu_disp)
    );

    health_channel #(
        .MAX_HEALTH    (MAX_HEALTH),
        .DRAIN_STEP    (DRAIN_STEP)
`ifdef HEALTH_INVULN_EN
        ,
        .INVULN_FRAMES (INVULN_FRAMES)
`endif
    ) u_akuma (
        .clk_i        (vga_clk),
        .rst_ni       (Reset_n),
        .hit_i        (AkumaHit),
        .damage_i     (AkumaDamage),
        .frame_tick_i (drain_tick),
        .enable_i     (hits_en),
        .reload_i     (round_start),
        .true_o       (akuma_true),
        .disp_o       (akuma_disp)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        winner_d   = winner_q;
        ryu_ko_d   = ryu_zero;
        akuma_ko_d = akuma_zero;
        if (round_start) begin
            state_d    = StFight;
            hold_d     = '0;
            winner_d   = WinNone;
            ryu_ko_d   = 1'b0;
            akuma_ko_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: ;
                StFight: begin
                    if (ryu_zero || akuma_zero) begin
                        state_d = StKoHold;
                        hold_d  = '0;
                        if (ryu_zero && akuma_zero) begin
                            winner_d = WinDraw;
                        end else if (akuma_zero) begin
                            winner_d = WinRyu;
                        end else begin
                            winner_d = WinAkuma;
                        end
                    end
                end
                StKoHold: begin
                    // Hold frames only count once both bars have caught up.
                    if (frame_tick && settled) begin
                        hold_d = hold_q + HoldW'(1);
                        if (hold_d == HoldW'(KO_HOLD_FRAMES)) begin
                            state_d = StDone;
                        end
                    end
                end
            endcase
        end
        round_over_d = (state_d == StDone);
    end

    always_ff @(posedge vga_clk) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            winner_q     <= WinNone;
            ryu_ko_q     <= 1'b0;
            akuma_ko_q   <= 1'b0;
            round_over_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            winner_q     <= winner_d;
            ryu_ko_q     <= ryu_ko_d;
            akuma_ko_q   <= akuma_ko_d;
            round_over_q <= round_over_d;
        end
    end

    assign RyuHealth   = ryu_disp;
    assign AkumaHealth = akuma_disp;
    assign RyuKO       = ryu_ko_q;
    assign AkumaKO     = akuma_ko_q;
    assign winner      = winner_q;
    assign round_over  = round_over_q;

endmodule

// File: tb/tb_health_manager.sv
// Self-checking bench for health_manager: vector table plus scoreboarded
// hand sequences for drain, KO hold, draw, restart and invulnerability.
module tb_health_manager;
    import health_pkg::*;

`ifdef HEALTH_INVULN_EN
    localparam bit Inv = 1'b1;
`else
    localparam bit Inv = 1'b0;
`endif

    logic       vga_clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       round_start = 1'b0;
    logic       RyuHit = 1'b0;
    logic [7:0] RyuDamage = 8'd0;
    logic       AkumaHit = 1'b0;
    logic [7:0] AkumaDamage = 8'd0;
    logic [7:0] RyuHealth, AkumaHealth;
    logic       RyuKO, AkumaKO;
    logic [1:0] winner;
    logic       round_over;

    health_manager dut (
        .vga_clk     (vga_clk),
        .Reset_n     (Reset_n),
        .frame_tick  (frame_tick),
        .round_start (round_start),
        .RyuHit      (RyuHit),
        .RyuDamage   (RyuDamage),
        .AkumaHit    (AkumaHit),
        .AkumaDamage (AkumaDamage),
        .RyuHealth   (RyuHealth),
        .AkumaHealth (AkumaHealth),
        .RyuKO       (RyuKO),
        .AkumaKO     (AkumaKO),
        .winner      (winner),
        .round_over  (round_over)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        string      name;
        int         rd, ad, rt, at;
        bit         rko, ako;
        logic [1:0] win;
        bit         over;
        logic [1:0] st;
    } exp_t;

    typedef struct {
        string      name;
        bit         st, rh;
        logic [7:0] rdmg;
        bit         ah;
        logic [7:0] admg;
        bit         tk;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   n_chk = 0;
    int   n_err = 0;

    // Current expectation, updated by the sequences before each cycle.
    int         x_rd, x_ad, x_rt, x_at;
    bit         x_rko, x_ako;
    logic [1:0] x_win;
    bit         x_over;
    logic [1:0] x_st;

    function automatic int drain(input int d, input int t);
        return (d - 2 > t) ? d - 2 : t;
    endfunction

    function automatic vec_t mk(input string nm, input bit st, rh, input int rdmg, input bit ah,
                                input int admg, input bit tk, input int rd, ad, rt, at,
                                input bit rko, ako, input int win, input bit over,
                                input logic [1:0] s);
        vec_t v;
        v.name = nm; v.st = st; v.rh = rh; v.rdmg = 8'(rdmg);
        v.ah = ah; v.admg = 8'(admg); v.tk = tk;
        v.e.name = nm; v.e.rd = rd; v.e.ad = ad; v.e.rt = rt; v.e.at = at;
        v.e.rko = rko; v.e.ako = ako; v.e.win = 2'(win); v.e.over = over; v.e.st = s;
        return v;
    endfunction

    task automatic chk(input string nm, input string fld, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
        end
    endtask

    task automatic fresh();
        x_rd = 246; x_ad = 246; x_rt = 246; x_at = 246;
        x_rko = 0; x_ako = 0; x_win = 2'b00; x_over = 0; x_st = StFight;
    endtask

    task automatic push_exp(input string nm);
        exp_t e;
        e.name = nm; e.rd = x_rd; e.ad = x_ad; e.rt = x_rt; e.at = x_at;
        e.rko = x_rko; e.ako = x_ako; e.win = x_win; e.over = x_over; e.st = x_st;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        chk(e.name, "RyuHealth", int'(RyuHealth), e.rd);
        chk(e.name, "AkumaHealth", int'(AkumaHealth), e.ad);
        chk(e.name, "ryu_true", int'(dut.ryu_true), e.rt);
        chk(e.name, "akuma_true", int'(dut.akuma_true), e.at);
        chk(e.name, "RyuKO", int'(RyuKO), int'(e.rko));
        chk(e.name, "AkumaKO", int'(AkumaKO), int'(e.ako));
        chk(e.name, "winner", int'(winner), int'(e.win));
        chk(e.name, "round_over", int'(round_over), int'(e.over));
        chk(e.name, "state", int'(dut.state_q), int'(e.st));
    endtask

    task automatic cyc(input string nm, input bit st, rh, input int rdmg, input bit ah,
                       input int admg, input bit tk);
        round_start = st; RyuHit = rh; RyuDamage = 8'(rdmg);
        AkumaHit = ah; AkumaDamage = 8'(admg); frame_tick = tk;
        push_exp(nm);
        @(posedge vga_clk);
        #1;
        round_start = 0; RyuHit = 0; AkumaHit = 0; frame_tick = 0;
        pop_check();
    endtask

    task automatic apply_vec(input vec_t v);
        x_rd = v.e.rd; x_ad = v.e.ad; x_rt = v.e.rt; x_at = v.e.at;
        x_rko = v.e.rko; x_ako = v.e.ako; x_win = v.e.win; x_over = v.e.over; x_st = v.e.st;
        cyc(v.name, v.st, v.rh, int'(v.rdmg), v.ah, int'(v.admg), v.tk);
    endtask

    // Reset is held across round_start/hit/tick pulses, which must lose.
    task automatic do_reset(input string nm);
        Reset_n = 0; round_start = 1; RyuHit = 1; RyuDamage = 8'd50; frame_tick = 1;
        x_rd = 246; x_ad = 246; x_rt = 246; x_at = 246;
        x_rko = 0; x_ako = 0; x_win = 2'b00; x_over = 0; x_st = StIdle;
        push_exp(nm);
        repeat (2) begin
            @(posedge vga_clk);
            #1;
        end
        round_start = 0; RyuHit = 0; frame_tick = 0;
        pop_check();
        Reset_n = 1;
    endtask

    initial begin
        tbl[0] = mk("idle_hit",     0, 1, 50, 0, 0, 0, 246, 246, 246, 246, 0, 0, 0, 0, StIdle);
        tbl[1] = mk("idle_tick",    0, 0, 0, 1, 30, 1, 246, 246, 246, 246, 0, 0, 0, 0, StIdle);
        tbl[2] = mk("start",        1, 0, 0, 0, 0, 0, 246, 246, 246, 246, 0, 0, 0, 0, StFight);
        tbl[3] = mk("ryu_hit50",    0, 1, 50, 0, 0, 0, 246, 246, 196, 246, 0, 0, 0, 0, StFight);
        tbl[4] = mk("tick1",        0, 0, 0, 0, 0, 1, 244, 246, 196, 246, 0, 0, 0, 0, StFight);
        tbl[5] = mk("akuma_dmg0",   0, 0, 0, 1, 0, 0, 244, 246, 196, 246, 0, 0, 0, 0, StFight);
        tbl[6] = mk("hit_and_tick", 0, 0, 0, 1, 6, 1, 242, 246, 196, 240, 0, 0, 0, 0, StFight);
        tbl[7] = mk("tick3",        0, 0, 0, 0, 0, 1, 240, 244, 196, 240, 0, 0, 0, 0, StFight);
        tbl[8] = mk("tick4",        0, 0, 0, 0, 0, 1, 238, 242, 196, 240, 0, 0, 0, 0, StFight);
        tbl[9] = mk("tick5",        0, 0, 0, 0, 0, 1, 236, 240, 196, 240, 0, 0, 0, 0, StFight);

        do_reset("reset");
        for (int i = 0; i < 10; i++) apply_vec(tbl[i]);

        // Ryu drains 2 per tick down to 196 after 25 ticks in total.
        for (int i = 1; i <= 20; i++) begin
            x_rd = 236 - 2 * i;
            cyc("ryu_drain", 0, 0, 0, 0, 0, 1);
        end
        cyc("ryu_settled", 0, 0, 0, 0, 0, 1);

        // Restart mid-KO_HOLD; round_start also beats a same-cycle hit.
        fresh();
        cyc("start_beats_hit", 1, 1, 100, 0, 0, 0);
        x_at = 0;
        cyc("akuma_255_a", 0, 0, 0, 1, 255, 0);
        x_ako = 1; x_win = 2'b01; x_st = StKoHold;
        cyc("ko_entry_a", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            x_ad = drain(x_ad, x_at);
            cyc("ko_drain_a", 0, 0, 0, 0, 0, 1);
        end
        fresh();
        cyc("restart_mid_ko", 1, 0, 0, 0, 0, 1);

        // Saturating KO, full drain, then 120 settled hold frames.
        x_at = 0;
        cyc("akuma_255", 0, 0, 0, 1, 255, 0);
        x_ako = 1; x_win = 2'b01; x_st = StKoHold;
        cyc("ko_entry", 0, 0, 0, 0, 0, 0);
        cyc("hit_in_ko", 0, 1, 100, 0, 0, 0);
        for (int i = 0; i < 123; i++) begin
            x_ad = drain(x_ad, x_at);
            cyc("ko_drain", 0, 0, 0, 0, 0, 1);
        end
        for (int j = 1; j <= 120; j++) begin
            if (j == 120) begin
                x_over = 1; x_st = StDone;
            end
            cyc("ko_hold", 0, 0, 0, 0, 0, 1);
        end
        cyc("done_frozen", 0, 1, 50, 1, 50, 1);
        fresh();
        cyc("restart_done", 1, 0, 0, 0, 0, 0);

        // Simultaneous KO gives a draw.
        x_rt = 10; x_at = 10;
        cyc("both_to_10", 0, 1, 236, 1, 236, 0);
        x_rt = 0; x_at = 0;
        cyc("both_hit20", 0, 1, 20, 1, 20, 0);
        x_rko = 1; x_ako = 1; x_win = 2'b11; x_st = StKoHold;
        cyc("draw", 0, 0, 0, 0, 0, 0);

        // Invulnerability window: blocked until 30 ticks after the hit.
        fresh();
        cyc("inv_start", 1, 0, 0, 0, 0, 0);
        x_rt = 236;
        cyc("inv_hit1", 0, 1, 10, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            x_rd = drain(x_rd, x_rt);
            cyc("inv_tick_a", 0, 0, 0, 0, 0, 1);
        end
        x_rt = Inv ? 236 : 226;
        cyc("inv_hit2", 0, 1, 10, 0, 0, 0);
        for (int i = 0; i < 24; i++) begin
            x_rd = drain(x_rd, x_rt);
            cyc("inv_tick_b", 0, 0, 0, 0, 0, 1);
        end
        x_rt = Inv ? 236 : 216;
        cyc("inv_hit3", 0, 1, 10, 0, 0, 0);
        x_rd = drain(x_rd, x_rt);
        cyc("inv_tick_c", 0, 0, 0, 0, 0, 1);
        x_rt = Inv ? 226 : 206;
        cyc("inv_hit4", 0, 1, 10, 0, 0, 0);

        // Reset mid-drain reloads immediately.
        fresh();
        cyc("pre_reset_start", 1, 0, 0, 0, 0, 0);
        x_at = 146;
        cyc("akuma_hit100", 0, 0, 0, 1, 100, 0);
        for (int i = 0; i < 3; i++) begin
            x_ad = drain(x_ad, x_at);
            cyc("pre_reset_drain", 0, 0, 0, 0, 0, 1);
        end
        do_reset("reset_mid_drain");

        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d leftover, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
